// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter/sequencer sharing one ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   grant0;
  logic   grant1;

  // Pick the winner in IDLE: a lone valid port wins, contention is settled by prio.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Sequencer: accept -> drive ALU for one cycle -> capture and hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            alu_ctrl <= req0_op;
            alu_a    <= req0_a;
            alu_b    <= req0_b;
            rsp_id   <= 1'b0;
            prio     <= 1'b1;
            state    <= EXEC;
          end else if (grant1) begin
            alu_ctrl <= req1_op;
            alu_a    <= req1_a;
            alu_b    <= req1_b;
            rsp_id   <= 1'b1;
            prio     <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          rsp_flags  <= {alu_zero, alu_sign, alu_carry, alu_ovf};
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_sign, alu_carry, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Small ALU stand-in: 000 add, 001 sub (carry = borrow), 100 shift left, else xor.
  logic [32:0] wide;
  logic        c_f, o_f;
  always_comb begin
    wide = '0;
    c_f  = 1'b0;
    o_f  = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        c_f  = wide[32];
        o_f  = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
      end
      3'b001: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        c_f  = (alu_a < alu_b);
        o_f  = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
      end
      3'b100:  wide = {1'b0, alu_a << alu_b[4:0]};
      default: wide = {1'b0, alu_a ^ alu_b};
    endcase
    alu_out   = wide[31:0];
    alu_zero  = (wide[31:0] == 32'd0);
    alu_sign  = wide[31];
    alu_carry = c_f;
    alu_ovf   = o_f;
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready  = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0b exp 0", rsp_id); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %0h exp 0", rsp_result); end
    checks++; if (rsp_flags !== 4'd0) begin errors++; $display("FAIL reset_rsp_flags got %0h exp 0", rsp_flags); end
    checks++; if ({alu_ctrl, alu_a, alu_b} !== 67'd0) begin errors++; $display("FAIL reset_alu_regs got %0h/%0h/%0h exp 0", alu_ctrl, alu_a, alu_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %0b exp 00", {req0_ready, req1_ready}); end
    rst = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_op = 3'b100; req0_a = 32; req0_b = 2; rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_grant got %0b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++; if ({alu_ctrl, alu_a, alu_b} !== {3'b100, 32'd32, 32'd2}) begin errors++; $display("FAIL single_alu_in got %0h/%0h/%0h exp 4/20/2", alu_ctrl, alu_a, alu_b); end
    checks++; if ({busy, rsp_valid, req0_ready} !== 3'b100) begin errors++; $display("FAIL single_exec got busy/vld/rdy %0b exp 100", {busy, rsp_valid, req0_ready}); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_id} !== 2'b10) begin errors++; $display("FAIL single_rsp got vld/id %0b exp 10", {rsp_valid, rsp_id}); end
    checks++; if (rsp_result !== 32'd128 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL single_result got %0h/%0b exp 80/0000", rsp_result, rsp_flags); end
    @(negedge clk);
    #1;
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_idle got busy/vld %0b exp 00", {busy, rsp_valid}); end
    checks++; if ({alu_ctrl, alu_a, alu_b} !== {3'b100, 32'd32, 32'd2}) begin errors++; $display("FAIL single_alu_hold got %0h/%0h/%0h exp 4/20/2", alu_ctrl, alu_a, alu_b); end
    rsp_ready = 0;
  endtask

  // Both ports held valid from just after reset; grants must alternate starting at port 0.
  task automatic run_contention(input string tag, input int nops,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [31:0] res0, input logic [3:0] fl0,
                                input logic [31:0] res1, input logic [3:0] fl1);
    int acc_n = 0;
    int rsp_n = 0;
    int last_acc = -1;
    @(negedge clk);
    req0_valid = 1; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = 1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = 1;
    for (int cyc = 0; cyc < 80 && rsp_n < nops; cyc++) begin
      #1;
      if (acc_n < nops) begin
        checks++; if (busy !== ~(req0_ready | req1_ready)) begin errors++; $display("FAIL %s_busy cyc %0d got %0b exp %0b", tag, cyc, busy, ~(req0_ready | req1_ready)); end
      end
      if (req0_ready || req1_ready) begin
        checks++; if ({req0_ready, req1_ready} !== (acc_n[0] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL %s_grant #%0d got %0b exp %0b", tag, acc_n, {req0_ready, req1_ready}, acc_n[0] ? 2'b01 : 2'b10); end
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc !== 3) begin errors++; $display("FAIL %s_spacing #%0d got %0d exp 3", tag, acc_n, cyc - last_acc); end
        end
        last_acc = cyc;
        acc_n++;
      end
      if (rsp_valid) begin
        checks++; if (rsp_id !== rsp_n[0]) begin errors++; $display("FAIL %s_rsp_id #%0d got %0b exp %0b", tag, rsp_n, rsp_id, rsp_n[0]); end
        checks++; if ({rsp_result, rsp_flags} !== (rsp_n[0] ? {res1, fl1} : {res0, fl0})) begin errors++; $display("FAIL %s_rsp_data #%0d got %0h/%0b", tag, rsp_n, rsp_result, rsp_flags); end
        rsp_n++;
      end
      @(negedge clk);
      if (acc_n >= nops) begin
        req0_valid = 0;
        req1_valid = 0;
      end
    end
    checks++; if (rsp_n !== nops || acc_n !== nops) begin errors++; $display("FAIL %s_count got acc %0d rsp %0d exp %0d", tag, acc_n, rsp_n, nops); end
    rsp_ready = 0;
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    run_contention("simul", 2, 3'b000, 32'd1, 32'd1, 3'b001, 32'd5, 32'd3,
                   32'd2, 4'b0000, 32'd2, 4'b0000);
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    run_contention("b2b", 6, 3'b000, 32'hFFFF_FFFF, 32'd1, 3'b001, 32'd3, 32'd5,
                   32'd0, 4'b1010, 32'hFFFF_FFFE, 4'b0110);
  endtask

  task automatic test_stall();
    logic [37:0] snap;
    int ok_rdy = 1;
    int ok_hold = 1;
    @(negedge clk);
    req0_valid = 1; req0_op = 3'b000; req0_a = 7; req0_b = 9; rsp_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'b001; req1_a = 100; req1_b = 1;
    @(negedge clk);
    #1;
    snap = {rsp_valid, rsp_id, rsp_result, rsp_flags};
    checks++; if (snap !== {1'b1, 1'b0, 32'd16, 4'b0000}) begin errors++; $display("FAIL stall_rsp got %0h exp %0h", snap, {1'b1, 1'b0, 32'd16, 4'b0000}); end
    for (int i = 0; i < 5; i++) begin
      if (req0_ready || req1_ready) ok_rdy = 0;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== snap) ok_hold = 0;
      @(negedge clk);
      #1;
    end
    checks++; if (ok_hold !== 1) begin errors++; $display("FAIL stall_hold got %0d exp 1", ok_hold); end
    checks++; if (ok_rdy !== 1) begin errors++; $display("FAIL stall_ready got %0d exp 1", ok_rdy); end
    rsp_ready = 1;
    @(negedge clk);
    #1;
    checks++; if ({busy, rsp_valid, req1_ready} !== 3'b001) begin errors++; $display("FAIL stall_release got busy/vld/rdy1 %0b exp 001", {busy, rsp_valid, req1_ready}); end
    req1_valid = 0;
    rsp_ready = 0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %0b exp 0", req1_ready); end
    @(negedge clk);
    #1;
    checks++; if ({busy, alu_a} !== {1'b0, 32'd7}) begin errors++; $display("FAIL drop_no_latch got busy %0b a %0h exp 0/7", busy, alu_a); end
  endtask

  task automatic test_lone_requester();
    pulse_reset();
    req1_valid = 1; req1_op = 3'b001; req1_a = 10; req1_b = 4; rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL lone_grant got %0b exp 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd6}) begin errors++; $display("FAIL lone_rsp got %0b/%0b/%0h exp 1/1/6", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    req0_valid = 1; req0_op = 3'b000; req0_a = 2; req0_b = 2;
    req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL lone_then_both got %0b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd4}) begin errors++; $display("FAIL lone_second_rsp got %0b/%0b/%0h exp 1/0/4", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset_in_resp();
    int seen = 0;
    @(negedge clk);
    req0_valid = 1; req0_op = 3'b000; req0_a = 1; req0_b = 2; rsp_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstresp_pre got %0b exp 1", rsp_valid); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if ({rsp_valid, rsp_result, busy} !== 34'd0) begin errors++; $display("FAIL rstresp_clear got vld %0b res %0h busy %0b exp 0", rsp_valid, rsp_result, busy); end
    checks++; if ({rsp_flags, alu_a, rsp_id} !== 37'd0) begin errors++; $display("FAIL rstresp_regs got fl %0b a %0h id %0b exp 0", rsp_flags, alu_a, rsp_id); end
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstresp_ghost got %0d responses exp 0", seen); end
    rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_lone_requester();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares the single 32-bit ALU between two requesters, for example the main datapath and a future address/branch unit. It accepts one operation at a time over a valid/ready handshake and selects the winner round-robin. It drives the ALU's control and operand inputs from registers, captures the ALU result and flags, and returns them on a response channel tagged with the requester ID.

## Interface
- WIDTH, 32, operand/result width; must match the ALU datapath width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_op  in  3  port 0 ALU control code (opaque, forwarded unchanged)
- req0_a, req0_b  in  WIDTH  port 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1
- alu_ctrl  out  3  registered AluControl to ALU
- alu_a, alu_b  out  WIDTH  registered in_a/in_b to ALU
- alu_out  in  WIDTH  ALU result
- alu_zero, alu_sign, alu_carry, alu_ovf  in  1 each  ALU flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  port that issued the op (0/1)
- rsp_result  out  WIDTH  captured ALU result
- rsp_flags  out  4  {zero, sign, carry, overflow} captured with result
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE behaviour:
  - The winner is the only valid port if exactly one is valid.
  - If both are valid, the winner is the port named by priority pointer `prio`.
  - The winner's reqN_ready is asserted combinationally. The other port's ready is 0. Both are 0 if neither port is valid.
- Accept when reqN_valid && reqN_ready:
  - latch op/a/b into alu_ctrl/alu_a/alu_b;
  - latch the port number into rsp_id;
  - set `prio` to the other port;
  - go to EXEC.
- EXEC (exactly one cycle):
  - The ALU sees stable registered inputs.
  - At the end of the cycle, capture alu_out into rsp_result and {alu_zero, alu_sign, alu_carry, alu_ovf} into rsp_flags.
  - Set rsp_valid and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_result and rsp_flags stable until rsp_valid && rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
- In EXEC and RESP, both reqN_ready are 0. No new request is accepted until the FSM has returned to IDLE.
- alu_ctrl/alu_a/alu_b hold their last values after an op. They change only on accept.
- Requesters must hold valid and payload stable until accepted. The arbiter does not check this.
- Reset values:
  - state IDLE, `prio` = 0;
  - alu_ctrl = 0, alu_a = 0, alu_b = 0;
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0;
  - busy = 0.
- Reset mid-operation (EXEC or RESP): the op is discarded with no response and all registers take their reset values.

## Timing
- Request accepted at edge T:
  - ALU inputs are valid from T to T+1.
  - rsp_valid is high after edge T+1.
- If rsp_ready is already high, the response handshake completes at edge T+2. The FSM is in IDLE after T+2, and a new accept can occur at edge T+3.
- Peak throughput is one operation per 3 cycles. Response latency is 2 cycles plus any consumer stall.
- Fairness:
  - With both ports continuously valid, grants alternate 0,1,0,1,…
  - A port waits at most one foreign operation.
- rsp_ready asserted while in IDLE or EXEC has no effect.
- A valid that drops in IDLE before accept has no effect. Nothing is latched.

## Test plan
- Reset then single request:
  - Stimulus: req0 op=3'b100, a=32, b=2, rsp_ready=1.
  - req0_ready is high in the accept cycle.
  - Next cycle: alu_ctrl=3'b100, alu_a=32, alu_b=2.
  - Following cycle: rsp_valid=1, rsp_id=0, and rsp_result/rsp_flags equal the ALU outputs for those operands.
- Simultaneous requests after reset:
  - Stimulus: req0 (a=1, b=1) and req1 (a=5, b=3) both valid and held.
  - Port 0 is granted first (prio=0). Port 1 is granted at the next IDLE.
  - rsp_id sequence is 0 then 1; busy is high throughout except the IDLE cycles.
- Back-to-back contention:
  - Stimulus: both ports continuously valid for 6 ops.
  - rsp_id sequence is 0,1,0,1,0,1.
  - Exactly 3 cycles between accepts with rsp_ready=1.
- Response stall:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid/rsp_result/rsp_flags/rsp_id are stable for all 5 cycles.
  - req0_ready and req1_ready stay 0 throughout.
  - Handshake completes on the cycle rsp_ready=1; the FSM is in IDLE the next cycle.
- Lone requester pointer update:
  - Stimulus: req1 only, then req0 and req1 both valid.
  - First grant goes to port 1, making prio=0. The simultaneous case then grants port 0.
- Reset during RESP:
  - Stimulus: assert rst for 1 cycle while rsp_valid=1.
  - Next cycle: rsp_valid=0, rsp_result=0, busy=0.
  - No response for the discarded op ever appears.
